eth_cmd_parse: RTL and testbench
================================

Name: eth_cmd_parse

Overview:
- Sits directly upstream of the console's ETH section.
- Receives the byte stream of one command frame from the Ethernet RX MAC payload path.
- Checks the header, btype and checksum, then latches the 4-bit btype and 16-bit command.
- Presents them on read_btype/com_cmd with an fs_read/fd_read handshake, the flag pair the console consumes as fs_eth_read/fd_eth_read.

Parameters:
HEAD0, 8'h55, first header byte
HEAD1, 8'hAA, second header byte
GAP_MAX, 16'd1000, max clk cycles between rx_valid beats inside a frame before abort
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  payload byte from MAC
rx_valid  in  1  rx_data valid this cycle
rx_last  in  1  qualifies the final byte of a frame (only meaningful with rx_valid)
fs_read  out  1  new command available (held until fd_read)
fd_read  in  1  consumer has taken command
read_btype  out  4  btype of last accepted frame
com_cmd  out  16  command word of last accepted frame, {byte3, byte4}
err_cnt  out  ERR_W  count of rejected/dropped frames, saturating at all-ones
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; fs_read=0, read_btype=0, com_cmd=0, err_cnt=0, busy=0; gap timer cleared. Reset mid-frame or mid-handshake discards everything.
- Frame format is exactly 6 bytes: HEAD0, HEAD1, {4'h0,btype}, cmd_hi, cmd_lo, chk. rx_last is on chk only. chk = byte2^byte3^byte4.
- States: IDLE, H1, BT, CH, CL, CK, DRAIN, FLAG, WAIT.
- IDLE: on rx_valid with rx_data==HEAD0 and not rx_last -> H1. Any other byte: stay, no error counted; with rx_last it is a 1-byte runt and counts err.
- H1: ==HEAD1 -> BT.
- BT: upper nibble must be 0; capture btype into a shadow reg -> CH.
- CH and CL: capture into shadow regs, advancing CH -> CL -> CK.
- CK: on chk byte with rx_last=1 and checksum match -> FLAG. Shadow regs copy to read_btype/com_cmd on the same edge, so outputs change only for accepted frames.
- Any mismatch in H1/BT/CK: err++.
  - If rx_last was on that byte -> IDLE, else -> DRAIN.
  - rx_last arriving early in H1..CL: err++ -> IDLE.
  - chk byte without rx_last: err++ -> DRAIN.
- DRAIN: discard bytes until rx_valid&rx_last -> IDLE.
- Gap timer: counts cycles without rx_valid while in H1..CK or DRAIN; cleared on each rx_valid. On reaching GAP_MAX: err++ (DRAIN does not count again) -> IDLE.
- FLAG: fs_read=1 registered, asserted the cycle after chk byte is accepted (latency 1 clk from chk edge). On fd_read=1: fs_read=0 -> WAIT.
- WAIT: on fd_read=0 -> IDLE. Full 4-phase handshake; read_btype/com_cmd stable from FLAG entry until the next accepted frame.
- Bytes arriving in FLAG/WAIT are not buffered. Each rx_valid&rx_last seen in FLAG/WAIT increments err_cnt (dropped frame); the frame's bytes are ignored. Parser resumes at IDLE; a frame already in progress on return is caught by the IDLE header rule or rejected.
- err_cnt: saturates at 2^ERR_W-1, never wraps. If two error events coincide in one cycle, increment by 1.
- fd_read high while in IDLE..CK: ignored.

Decomposition:
- Package eth_cmd_pkg: state enum (9 states), HEAD0/HEAD1 defaults, frame length constant 6, btype width 4, command width 16.
- One sub-module eth_cmd_gap_timer: load-clear on rx_valid, enable while in frame, terminal pulse at GAP_MAX.

Test Plan:
1. Good frame: 55 AA 03 12 34 25 (rx_last on 25) -> fs_read=1 one cycle later; read_btype=4'h3, com_cmd=16'h1234; fd_read=1 -> fs_read=0 next cycle; fd_read=0 -> busy=0; err_cnt=0.
2. Bad checksum: 55 AA 03 12 34 26 -> no fs_read; read_btype/com_cmd keep previous values; err_cnt=1.
3. Long frame: 55 AA 03 12 34 25 77 (rx_last on 77) -> DRAIN then IDLE, err_cnt+1, no fs_read. Then back-to-back 55 AA 05 AB CD 63 -> com_cmd=16'hABCD, read_btype=5.
4. Gap timeout: 55 AA 03, then rx_valid low for GAP_MAX cycles -> IDLE at GAP_MAX, err_cnt+1. A later valid frame is accepted normally.
5. Overrun: hold fd_read=0 after test 1; send a second valid frame -> err_cnt+1, com_cmd still 16'h1234; fs_read stays 1.
6. Reset and saturation:
   - Pull rst low mid-frame (after 55 AA) and again during FLAG -> all outputs 0 immediately; the next good frame is accepted.
   - Drive 300 bad frames -> err_cnt=8'hFF and holds.

Source files
------------

// File: rtl/eth_cmd_pkg.sv
// -----------------------------------------------------------------------------
// eth_cmd_pkg
// Shared types and constants for the Ethernet command-frame parser.
//   state_t    : parser FSM states
//   HEAD0_DEF  : default first header byte
//   HEAD1_DEF  : default second header byte
//   FRAME_LEN  : bytes per command frame (HEAD0, HEAD1, btype, cmd_hi, cmd_lo, chk)
//   BTYPE_W    : width of the btype field
//   CMD_W      : width of the command word
//   frame_chk  : checksum over the btype and command bytes
// -----------------------------------------------------------------------------
package eth_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_H1,
    ST_BT,
    ST_CH,
    ST_CL,
    ST_CK,
    ST_DRAIN,
    ST_FLAG,
    ST_WAIT
  } state_t;

  localparam logic [7:0] HEAD0_DEF = 8'h55;
  localparam logic [7:0] HEAD1_DEF = 8'hAA;
  localparam int         FRAME_LEN = 6;
  localparam int         BTYPE_W   = 4;
  localparam int         CMD_W     = 16;

  function automatic logic [7:0] frame_chk(input logic [7:0] b2,
                                           input logic [7:0] b3,
                                           input logic [7:0] b4);
    return b2 ^ b3 ^ b4;
  endfunction

endpackage

// File: rtl/eth_cmd_gap_timer.sv
// -----------------------------------------------------------------------------
// eth_cmd_gap_timer
// Counts idle cycles (no rx_valid) while the parser is inside a frame and
// pulses expire on the GAP_MAX-th consecutive idle cycle.
//   clk, rst : clock, asynchronous active-low reset
//   enable   : parser is inside a frame (H1..CK or DRAIN)
//   clear    : a byte arrived this cycle; restarts the count
//   expire   : single-cycle terminal pulse, combinational from count/inputs
// -----------------------------------------------------------------------------
module eth_cmd_gap_timer #(
  parameter logic [15:0] GAP_MAX = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  logic [15:0] cnt;

  // The count already holds GAP_MAX-1 idle cycles, so this idle cycle is
  // the GAP_MAX-th one and the parser must abort on this edge.
  assign expire = enable && !clear && (cnt == GAP_MAX - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!enable || clear || expire) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/eth_cmd_parse.sv
// -----------------------------------------------------------------------------
// eth_cmd_parse
// Parses one 6-byte command frame from the RX MAC payload stream, validates
// header/btype/checksum and presents btype + command to the console's ETH
// section through a 4-phase fs_read/fd_read handshake.
//   clk, rst   : clock, asynchronous active-low reset
//   rx_data    : payload byte
//   rx_valid   : rx_data valid this cycle
//   rx_last    : final byte of a frame (qualified by rx_valid)
//   fs_read    : new command available, held until fd_read
//   fd_read    : consumer has taken the command
//   read_btype : btype of the last accepted frame
//   com_cmd    : command word {cmd_hi, cmd_lo} of the last accepted frame
//   err_cnt    : saturating count of rejected/dropped frames
//   busy       : parser is not in IDLE
// -----------------------------------------------------------------------------
module eth_cmd_parse
  import eth_cmd_pkg::*;
#(
  parameter logic [7:0]  HEAD0   = HEAD0_DEF,
  parameter logic [7:0]  HEAD1   = HEAD1_DEF,
  parameter logic [15:0] GAP_MAX = 16'd1000,
  parameter int          ERR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               rx_last,
  output logic               fs_read,
  input  logic               fd_read,
  output logic [BTYPE_W-1:0] read_btype,
  output logic [CMD_W-1:0]   com_cmd,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               busy
);

  state_t             state;
  logic [BTYPE_W-1:0] btype_sh;
  logic [7:0]         cmd_hi_sh;
  logic [7:0]         cmd_lo_sh;
  logic               in_frame;
  logic               gap_expire;
  logic               byte_last;
  logic [7:0]         chk_exp;

  assign in_frame  = state inside {ST_H1, ST_BT, ST_CH, ST_CL, ST_CK, ST_DRAIN};
  assign byte_last = rx_valid && rx_last;
  assign chk_exp   = frame_chk({4'h0, btype_sh}, cmd_hi_sh, cmd_lo_sh);
  assign busy      = (state != ST_IDLE);

  eth_cmd_gap_timer #(
    .GAP_MAX (GAP_MAX)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (in_frame),
    .clear  (rx_valid),
    .expire (gap_expire)
  );

  // Saturating increment; at most one error event can occur per cycle since
  // a timeout requires an idle cycle and every other event requires a byte.
  function automatic logic [ERR_W-1:0] bump(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      fs_read    <= 1'b0;
      read_btype <= '0;
      com_cmd    <= '0;
      err_cnt    <= '0;
      btype_sh   <= '0;
      cmd_hi_sh  <= '0;
      cmd_lo_sh  <= '0;
    end else if (gap_expire) begin
      // DRAIN already counted the error for this frame.
      if (state != ST_DRAIN) err_cnt <= bump(err_cnt);
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_data == HEAD0 && !rx_last) state <= ST_H1;
            else if (rx_last)                 err_cnt <= bump(err_cnt);
          end
        end

        ST_H1: begin
          if (rx_valid) begin
            if (rx_data != HEAD1 || rx_last) begin
              err_cnt <= bump(err_cnt);
              state   <= rx_last ? ST_IDLE : ST_DRAIN;
            end else begin
              state <= ST_BT;
            end
          end
        end

        ST_BT: begin
          if (rx_valid) begin
            if (rx_data[7:4] != 4'h0 || rx_last) begin
              err_cnt <= bump(err_cnt);
              state   <= rx_last ? ST_IDLE : ST_DRAIN;
            end else begin
              btype_sh <= rx_data[3:0];
              state    <= ST_CH;
            end
          end
        end

        ST_CH: begin
          if (rx_valid) begin
            if (rx_last) begin
              err_cnt <= bump(err_cnt);
              state   <= ST_IDLE;
            end else begin
              cmd_hi_sh <= rx_data;
              state     <= ST_CL;
            end
          end
        end

        ST_CL: begin
          if (rx_valid) begin
            if (rx_last) begin
              err_cnt <= bump(err_cnt);
              state   <= ST_IDLE;
            end else begin
              cmd_lo_sh <= rx_data;
              state     <= ST_CK;
            end
          end
        end

        ST_CK: begin
          if (rx_valid) begin
            if (rx_last && rx_data == chk_exp) begin
              // Outputs only move for accepted frames.
              read_btype <= btype_sh;
              com_cmd    <= {cmd_hi_sh, cmd_lo_sh};
              fs_read    <= 1'b1;
              state      <= ST_FLAG;
            end else begin
              err_cnt <= bump(err_cnt);
              state   <= rx_last ? ST_IDLE : ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (byte_last) state <= ST_IDLE;
        end

        ST_FLAG: begin
          if (byte_last) err_cnt <= bump(err_cnt);
          if (fd_read) begin
            fs_read <= 1'b0;
            state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (byte_last) err_cnt <= bump(err_cnt);
          if (!fd_read) state <= ST_IDLE;
        end

        // NOTE: an explicit default recovers from any unused encoding
        // instead of leaving the state register stuck.
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_cmd_parse.sv
// -----------------------------------------------------------------------------
// tb_eth_cmd_parse
// Directed self-checking bench for eth_cmd_parse with hand-computed
// expectations. Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_eth_cmd_parse;
  import eth_cmd_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        fs_read;
  logic        fd_read;
  logic [3:0]  read_btype;
  logic [15:0] com_cmd;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  eth_cmd_parse dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_last    (rx_last),
    .fs_read    (fs_read),
    .fd_read    (fd_read),
    .read_btype (read_btype),
    .com_cmd    (com_cmd),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bytes are packed MSB-first: the first byte sent is bytes[8*n-1 -: 8].
  task automatic send_frame(input logic [63:0] bytes, input int n,
                            input bit with_last);
    for (int i = 0; i < n; i++) begin
      rx_data  = bytes[8*(n-1-i) +: 8];
      rx_valid = 1'b1;
      rx_last  = with_last && (i == n - 1);
      tick();
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic handshake();
    fd_read = 1'b1;
    tick();
    fd_read = 1'b0;
    tick();
  endtask

  initial begin
    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    fd_read  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_fs",    {31'd0, fs_read}, 32'd0);
    check("rst_cmd",   {16'd0, com_cmd}, 32'd0);
    check("rst_err",   {24'd0, err_cnt}, 32'd0);
    check("rst_busy",  {31'd0, busy},    32'd0);
    rst = 1'b1;
    tick();

    // Good frame: fs_read rises on the chk edge
    send_frame(64'h55AA03123425, FRAME_LEN, 1'b1);
    check("good_fs",    {31'd0, fs_read},    32'd1);
    check("good_btype", {28'd0, read_btype}, 32'h3);
    check("good_cmd",   {16'd0, com_cmd},    32'h1234);
    check("good_err",   {24'd0, err_cnt},    32'd0);

    // Overrun while fs_read is pending: frame dropped and counted
    send_frame(64'h55AA05ABCD63, FRAME_LEN, 1'b1);
    check("ovr_err", {24'd0, err_cnt}, 32'd1);
    check("ovr_cmd", {16'd0, com_cmd}, 32'h1234);
    check("ovr_fs",  {31'd0, fs_read}, 32'd1);

    // 4-phase handshake
    fd_read = 1'b1;
    tick();
    check("hs_fs_low", {31'd0, fs_read}, 32'd0);
    check("hs_busy",   {31'd0, busy},    32'd1);
    fd_read = 1'b0;
    tick();
    check("hs_idle", {31'd0, busy}, 32'd0);

    // Bad checksum
    send_frame(64'h55AA03123426, FRAME_LEN, 1'b1);
    check("badchk_fs",  {31'd0, fs_read},    32'd0);
    check("badchk_cmd", {16'd0, com_cmd},    32'h1234);
    check("badchk_bt",  {28'd0, read_btype}, 32'h3);
    check("badchk_err", {24'd0, err_cnt},    32'd2);

    // Long frame drains, then back-to-back good frame
    send_frame(64'h55AA0312342577, 7, 1'b1);
    check("long_err",  {24'd0, err_cnt}, 32'd3);
    check("long_busy", {31'd0, busy},    32'd0);
    check("long_fs",   {31'd0, fs_read}, 32'd0);
    send_frame(64'h55AA05ABCD63, FRAME_LEN, 1'b1);
    check("b2b_fs",    {31'd0, fs_read},    32'd1);
    check("b2b_cmd",   {16'd0, com_cmd},    32'hABCD);
    check("b2b_btype", {28'd0, read_btype}, 32'h5);
    check("b2b_err",   {24'd0, err_cnt},    32'd3);
    handshake();

    // Gap timeout: still busy after GAP_MAX-1 idle cycles, IDLE at GAP_MAX
    send_frame(64'h55AA03, 3, 1'b0);
    repeat (999) tick();
    check("gap_pre_busy", {31'd0, busy},    32'd1);
    check("gap_pre_err",  {24'd0, err_cnt}, 32'd3);
    tick();
    check("gap_busy", {31'd0, busy},    32'd0);
    check("gap_err",  {24'd0, err_cnt}, 32'd4);
    send_frame(64'h55AA0F00010E, FRAME_LEN, 1'b1);
    check("gap_next_fs",  {31'd0, fs_read},    32'd1);
    check("gap_next_cmd", {16'd0, com_cmd},    32'h0001);
    check("gap_next_bt",  {28'd0, read_btype}, 32'hF);
    handshake();

    // Early rx_last in CH, 1-byte runt, stray non-header byte, bad btype
    send_frame(64'h55AA0312, 4, 1'b1);
    check("early_err",  {24'd0, err_cnt}, 32'd5);
    check("early_busy", {31'd0, busy},    32'd0);
    send_frame(64'h55, 1, 1'b1);
    check("runt_err", {24'd0, err_cnt}, 32'd6);
    send_frame(64'h33, 1, 1'b0);
    check("stray_err",  {24'd0, err_cnt}, 32'd6);
    check("stray_busy", {31'd0, busy},    32'd0);
    send_frame(64'h55AA13123426, FRAME_LEN, 1'b1);
    check("btype_err",  {24'd0, err_cnt}, 32'd7);
    check("btype_busy", {31'd0, busy},    32'd0);
    check("btype_cmd",  {16'd0, com_cmd}, 32'h0001);

    // Reset mid-frame clears everything immediately
    send_frame(64'h55AA, 2, 1'b0);
    rst = 1'b0;
    #1;
    check("rstmid_err",  {24'd0, err_cnt},    32'd0);
    check("rstmid_cmd",  {16'd0, com_cmd},    32'd0);
    check("rstmid_bt",   {28'd0, read_btype}, 32'd0);
    check("rstmid_busy", {31'd0, busy},       32'd0);
    tick();
    rst = 1'b1;
    tick();
    send_frame(64'h55AA03123425, FRAME_LEN, 1'b1);
    check("rstmid_next_fs",  {31'd0, fs_read}, 32'd1);
    check("rstmid_next_cmd", {16'd0, com_cmd}, 32'h1234);

    // Reset during FLAG
    rst = 1'b0;
    #1;
    check("rstflag_fs",   {31'd0, fs_read},    32'd0);
    check("rstflag_cmd",  {16'd0, com_cmd},    32'd0);
    check("rstflag_bt",   {28'd0, read_btype}, 32'd0);
    check("rstflag_busy", {31'd0, busy},       32'd0);
    tick();
    rst = 1'b1;
    tick();
    send_frame(64'h55AA05ABCD63, FRAME_LEN, 1'b1);
    check("rstflag_next_fs",  {31'd0, fs_read}, 32'd1);
    check("rstflag_next_cmd", {16'd0, com_cmd}, 32'hABCD);
    handshake();

    // Saturation: 300 bad-checksum frames
    for (int i = 0; i < 254; i++) send_frame(64'h55AA03123426, FRAME_LEN, 1'b1);
    check("sat_254", {24'd0, err_cnt}, 32'hFE);
    send_frame(64'h55AA03123426, FRAME_LEN, 1'b1);
    check("sat_255", {24'd0, err_cnt}, 32'hFF);
    for (int i = 0; i < 45; i++) send_frame(64'h55AA03123426, FRAME_LEN, 1'b1);
    check("sat_hold", {24'd0, err_cnt}, 32'hFF);
    check("sat_cmd",  {16'd0, com_cmd}, 32'hABCD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
